// File: rtl/approx_error_sweeper.sv
// Sweeps every input vector of an approximate circuit and accumulates error statistics
// against an exact model. Define ASW_ERR_SUM_EN to add the err_sum accumulator and port.
module approx_error_sweeper #(
    parameter int N_IN     = 4,
    parameter int APPROX_W = 2,
    parameter int EXACT_W  = 3,
    parameter int ET       = 5
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   start,
    output logic [N_IN-1:0]                                        vec,
    input  logic [APPROX_W-1:0]                                    approx_i,
    input  logic [EXACT_W-1:0]                                     exact_i,
    output logic                                                   busy,
    output logic                                                   done,
    output logic [((APPROX_W > EXACT_W) ? APPROX_W : EXACT_W)-1:0] max_err,
    output logic [N_IN-1:0]                                        worst_vec,
    output logic [N_IN:0]                                          err_count,
    output logic                                                   violation
`ifdef ASW_ERR_SUM_EN
    ,
    output logic [((APPROX_W > EXACT_W) ? APPROX_W : EXACT_W)+N_IN-1:0] err_sum
`endif
);

    localparam int W = (APPROX_W > EXACT_W) ? APPROX_W : EXACT_W;
    localparam logic [N_IN-1:0] VEC_LAST = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_next;

    // One-deep sample stage: the circuit output for vec is captured alongside vec itself.
    logic                s_valid;
    logic [N_IN-1:0]     s_vec;
    logic [APPROX_W-1:0] s_approx;
    logic [EXACT_W-1:0]  s_exact;

    logic [W-1:0] exact_z, approx_z, err;

    assign exact_z  = W'(s_exact);
    assign approx_z = W'(s_approx);
    assign err      = (exact_z >= approx_z) ? (exact_z - approx_z) : (approx_z - exact_z);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = SWEEP;
            end
            SWEEP: begin
                busy = 1'b1;
                if (vec == VEC_LAST) state_next = DRAIN;
            end
            DRAIN: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec       <= '0;
            s_valid   <= 1'b0;
            s_vec     <= '0;
            s_approx  <= '0;
            s_exact   <= '0;
            max_err   <= '0;
            worst_vec <= '0;
            err_count <= '0;
`ifdef ASW_ERR_SUM_EN
            err_sum   <= '0;
`endif
        end else begin
            s_valid <= (state == SWEEP);
            if (state == SWEEP) begin
                s_vec    <= vec;
                s_approx <= approx_i;
                s_exact  <= exact_i;
                vec      <= vec + N_IN'(1);
            end
            if (state == IDLE && start) begin
                vec       <= '0;
                max_err   <= '0;
                worst_vec <= '0;
                err_count <= '0;
`ifdef ASW_ERR_SUM_EN
                err_sum   <= '0;
`endif
            end else if (s_valid) begin
                // Strict compare keeps the earliest vector on ties.
                if (err > max_err) begin
                    max_err   <= err;
                    worst_vec <= s_vec;
                end
                if (err != '0) err_count <= err_count + (N_IN+1)'(1);
`ifdef ASW_ERR_SUM_EN
                err_sum <= err_sum + (W+N_IN)'(err);
`endif
            end
        end
    end

    assign violation = (int'(max_err) > ET);

endmodule

// File: tb/tb_approx_error_sweeper.sv
// Directed bench for approx_error_sweeper: a table of circuit patterns with hand-computed
// statistics, plus reset-abort and mid-sweep restart sequences.
module tb_approx_error_sweeper;

    localparam int N_IN     = 4;
    localparam int APPROX_W = 2;
    localparam int EXACT_W  = 3;
    localparam int ET       = 5;
    localparam int W        = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [N_IN-1:0]     vec;
    logic [APPROX_W-1:0] approx_i;
    logic [EXACT_W-1:0]  exact_i;
    logic                busy;
    logic                done;
    logic [W-1:0]        max_err;
    logic [N_IN-1:0]     worst_vec;
    logic [N_IN:0]       err_count;
    logic                violation;
`ifdef ASW_ERR_SUM_EN
    logic [W+N_IN-1:0]   err_sum;
`endif

    int mode;
    int n_tests = 0;
    int n_fail  = 0;

    approx_error_sweeper #(
        .N_IN(N_IN), .APPROX_W(APPROX_W), .EXACT_W(EXACT_W), .ET(ET)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .vec(vec),
        .approx_i(approx_i), .exact_i(exact_i),
        .busy(busy), .done(done), .max_err(max_err), .worst_vec(worst_vec),
        .err_count(err_count), .violation(violation)
`ifdef ASW_ERR_SUM_EN
        , .err_sum(err_sum)
`endif
    );

    always #5 clk = ~clk;

    // Circuit patterns, combinational in vec.
    always_comb begin
        approx_i = '0;
        exact_i  = '0;
        case (mode)
            0: begin approx_i = vec[1:0]; exact_i = {1'b0, vec[1:0]}; end
            1: begin approx_i = 2'd0;     exact_i = vec[2:0];         end
            2: begin approx_i = 2'd0;     exact_i = 3'd3;             end
            3: begin approx_i = vec[1:0]; exact_i = 3'd0;             end
            4: begin approx_i = vec[1:0]; exact_i = vec[3:1];         end
            5: begin approx_i = 2'd0;     exact_i = (vec == 4'd10) ? 3'd5 : 3'd0; end
            default: ;
        endcase
    end

    typedef struct {
        int mode;
        int e_max;
        int e_worst;
        int e_count;
        int e_viol;
        int e_sum;
    } row_t;

    row_t tbl[6];

    int prev_valid = 0;
    int prev_max, prev_worst, prev_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Starts a sweep in the next cycle, optionally re-pulsing start when vec hits restart_vec,
    // and returns at the negedge of the done cycle.
    task automatic run_sweep(input row_t r, input int restart_vec);
        int found_k;
        found_k = 0;
        @(negedge clk);
        if (prev_valid != 0) begin
            check("post_done_low", {31'd0, done}, 0);
            check("post_busy_low", {31'd0, busy}, 0);
            check("hold_max_err", 32'(max_err), prev_max);
            check("hold_worst_vec", 32'(worst_vec), prev_worst);
            check("hold_err_count", 32'(err_count), prev_count);
        end
        mode  = r.mode;
        start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = (int'(vec) == restart_vec) ? 1'b1 : 1'b0;
            if (k == 1) begin
                check("busy_after_start", {31'd0, busy}, 1);
                check("clear_max_err", 32'(max_err), 0);
                check("clear_err_count", 32'(err_count), 0);
            end
            if (done) begin
                found_k = k;
                break;
            end
        end
        start = 1'b0;
        check("done_latency", found_k, 18);
        check("max_err", 32'(max_err), r.e_max);
        check("worst_vec", 32'(worst_vec), r.e_worst);
        check("err_count", 32'(err_count), r.e_count);
        check("violation", {31'd0, violation}, r.e_viol);
`ifdef ASW_ERR_SUM_EN
        check("err_sum", 32'(err_sum), r.e_sum);
`endif
        prev_valid = 1;
        prev_max   = r.e_max;
        prev_worst = r.e_worst;
        prev_count = r.e_count;
    endtask

    initial begin
        int found;
        int done_seen;
        row_t restart_row;

        tbl[0] = '{mode: 0, e_max: 0, e_worst: 0,  e_count: 0,  e_viol: 0, e_sum: 0};
        tbl[1] = '{mode: 1, e_max: 7, e_worst: 7,  e_count: 14, e_viol: 1, e_sum: 56};
        tbl[2] = '{mode: 2, e_max: 3, e_worst: 0,  e_count: 16, e_viol: 0, e_sum: 48};
        tbl[3] = '{mode: 3, e_max: 3, e_worst: 3,  e_count: 12, e_viol: 0, e_sum: 24};
        tbl[4] = '{mode: 4, e_max: 6, e_worst: 12, e_count: 14, e_viol: 1, e_sum: 40};
        tbl[5] = '{mode: 5, e_max: 5, e_worst: 10, e_count: 1,  e_viol: 0, e_sum: 5};

        mode  = 0;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_vec", 32'(vec), 0);
        check("rst_max_err", 32'(max_err), 0);
        check("rst_err_count", 32'(err_count), 0);
        rst = 1'b0;

        // Consecutive rows start in the cycle right after the previous done.
        for (int i = 0; i < 6; i++) run_sweep(tbl[i], -1);

        // Reset while vec==5 aborts the sweep with no done pulse.
        @(negedge clk);
        mode  = 1;
        start = 1'b1;
        found = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (vec == 4'd5) begin
                found = 1;
                break;
            end
        end
        check("abort_reach_vec5", found, 1);
        check("abort_pre_max_err", 32'(max_err), 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_vec", 32'(vec), 0);
        check("abort_max_err", 32'(max_err), 0);
        check("abort_worst_vec", 32'(worst_vec), 0);
        check("abort_err_count", 32'(err_count), 0);
        done_seen = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done) done_seen = 1;
        end
        check("abort_no_done", done_seen, 0);

        // Start re-pulsed at vec==9 must neither restart nor extend the sweep.
        prev_valid  = 0;
        restart_row = tbl[4];
        run_sweep(restart_row, 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
